// File: rtl/uart_rx_if.sv
// Received-word bus from uart_rx to the receive FIFO / register block.
// master drives the word and flags; slave consumes them with no backpressure.
interface uart_rx_if;
    logic [7:0] RxData;
    logic       RxValid;
    logic       FrameErr;
    logic       ParityErr;
    logic       BreakErr;

    modport master (output RxData, RxValid, FrameErr, ParityErr, BreakErr);
    modport slave  (input  RxData, RxValid, FrameErr, ParityErr, BreakErr);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, centre-sampled, 5-8 data bits, stop-bit and break checks.
// Define UART_RX_PARITY_EN to build the parity state and ParityErr; otherwise PEN/EPS are ignored.
module uart_rx (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       Baud16,
    input  logic       En,
    input  logic       RxD,
    input  logic [1:0] WLEN,
    input  logic       PEN,
    input  logic       EPS,
    uart_rx_if.master  rx
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHi
    } state_t;

    state_t     state;
    logic       rxd_m;
    logic       rxd_s;
    logic [3:0] cnt;
    logic [2:0] bitidx;
    logic [7:0] data_q;
    logic [1:0] wlen_q;
    logic       last_bit;
    logic       brk;

`ifdef UART_RX_PARITY_EN
    logic       pen_q;
    logic       eps_q;
    logic       par_q;
    logic       par_err;

    assign par_err = pen_q & (((^data_q) ^ par_q) != ~eps_q);
    assign brk     = (data_q == 8'h00) & ~rxd_s & ~(pen_q & par_q);
`else
    logic       unused_cfg;

    assign unused_cfg = PEN ^ EPS;
    assign brk        = (data_q == 8'h00) & ~rxd_s;
`endif

    assign last_bit = (bitidx == ({1'b0, wlen_q} + 3'd4));

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= RxD;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state        <= StIdle;
            cnt          <= 4'd0;
            bitidx       <= 3'd0;
            data_q       <= 8'h00;
            wlen_q       <= 2'b00;
`ifdef UART_RX_PARITY_EN
            pen_q        <= 1'b0;
            eps_q        <= 1'b0;
            par_q        <= 1'b0;
`endif
            rx.RxData    <= 8'h00;
            rx.RxValid   <= 1'b0;
            rx.FrameErr  <= 1'b0;
            rx.ParityErr <= 1'b0;
            rx.BreakErr  <= 1'b0;
        end else begin
            rx.RxValid <= 1'b0;
            if (!En) begin
                state <= StIdle;
                cnt   <= 4'd0;
            end else if (Baud16) begin
                case (state)
                    StIdle: begin
                        if (!rxd_s) begin
                            state <= StStart;
                            cnt   <= 4'd0;
                        end
                    end
                    StStart: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            if (!rxd_s) begin
                                state  <= StData;
                                cnt    <= 4'd0;
                                bitidx <= 3'd0;
                                data_q <= 8'h00;
                                wlen_q <= WLEN;
`ifdef UART_RX_PARITY_EN
                                pen_q  <= PEN;
                                eps_q  <= EPS;
`endif
                            end else begin
                                state <= StIdle;
                            end
                        end
                    end
                    StData: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            data_q[bitidx] <= rxd_s;
                            bitidx         <= bitidx + 3'd1;
                            if (last_bit) begin
`ifdef UART_RX_PARITY_EN
                                state <= pen_q ? StParity : StStop;
`else
                                state <= StStop;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            par_q <= rxd_s;
                            state <= StStop;
                        end
                    end
`endif
                    StStop: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            rx.RxData    <= data_q;
                            rx.RxValid   <= 1'b1;
                            rx.FrameErr  <= ~rxd_s;
                            rx.BreakErr  <= brk;
`ifdef UART_RX_PARITY_EN
                            rx.ParityErr <= par_err;
`else
                            rx.ParityErr <= 1'b0;
`endif
                            state        <= rxd_s ? StIdle : StWaitHi;
                        end
                    end
                    // A held-low line must go high before another start can be seen.
                    StWaitHi: begin
                        if (rxd_s) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model, per-cycle output compare,
// directed cases plus randomized frames. Baud16 pulses every 4 CLKs (64 CLKs per bit).
module tb_uart_rx;
    logic       CLK    = 1'b0;
    logic       RESETn = 1'b0;
    logic       Baud16 = 1'b0;
    logic       En     = 1'b0;
    logic       RxD    = 1'b1;
    logic [1:0] WLEN   = 2'b11;
    logic       PEN    = 1'b0;
    logic       EPS    = 1'b0;

    uart_rx_if rx ();

    uart_rx dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .Baud16 (Baud16),
        .En     (En),
        .RxD    (RxD),
        .WLEN   (WLEN),
        .PEN    (PEN),
        .EPS    (EPS),
        .rx     (rx)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses  = 0;
    logic [10:0] exp_q[$];   // {data, frame, parity, break}
    logic [10:0] hold_w  = 11'd0;

    always #5 CLK = ~CLK;

    initial forever begin
        repeat (3) @(posedge CLK);
        #1 Baud16 = 1'b1;
        @(posedge CLK);
        #1 Baud16 = 1'b0;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Every cycle: a pulse must match the next modelled word, otherwise outputs hold.
    always @(negedge CLK) begin
        logic [10:0] cur;
        cur = {rx.RxData, rx.FrameErr, rx.ParityErr, rx.BreakErr};
        if (!RESETn) begin
            check("reset_out", {21'd0, cur}, 32'd0);
            check("reset_valid", {31'd0, rx.RxValid}, 32'd0);
            hold_w = 11'd0;
            exp_q.delete();
        end else if (rx.RxValid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, rx.RxValid}, 32'd0);
            end else begin
                hold_w = exp_q.pop_front();
                check("word", {21'd0, cur}, {21'd0, hold_w});
            end
        end else begin
            check("hold", {21'd0, cur}, {21'd0, hold_w});
        end
    end

    task automatic line(input logic b, input int n);
        RxD = b;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge CLK);
            t++;
        end
        if (t > 0) #1;
        check("pulse_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] wl, input logic pn,
                              input logic ep, input logic pb, input logic sb);
        int         len;
        logic [7:0] m;
        logic       pe_eff;
        len = int'(wl) + 5;
        m   = 8'h00;
        for (int i = 0; i < len; i++) m[i] = d[i];
`ifdef UART_RX_PARITY_EN
        pe_eff = pn;
`else
        pe_eff = 1'b0;
`endif
        exp_q.push_back({m, ~sb, pe_eff && (((^m) ^ pb) != ~ep),
                         (m == 8'h00) && !sb && !(pe_eff && pb)});
        WLEN = wl;
        PEN  = pn;
        EPS  = ep;
        line(1'b0, 48);
        WLEN = 2'($urandom);
        PEN  = 1'($urandom);
        EPS  = 1'($urandom);
        line(1'b0, 16);
        for (int i = 0; i < len; i++) line(d[i], 64);
        if (pe_eff) line(pb, 64);
        line(sb, 64);
    endtask

    initial begin
        int p;
        repeat (5) @(posedge CLK);
        #1;
        check("rst_data", {24'd0, rx.RxData}, 32'h00);
        check("rst_valid", {31'd0, rx.RxValid}, 32'd0);
        RESETn = 1'b1;
        line(1'b1, 10);
        check("post_rst_data", {24'd0, rx.RxData}, 32'h00);
        check("post_rst_flags", {29'd0, rx.FrameErr, rx.ParityErr, rx.BreakErr}, 32'd0);
        En = 1'b1;
        line(1'b1, 64);

        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        line(1'b1, 64);
        wait_drain();
        check("a5_data", {24'd0, rx.RxData}, 32'hA5);
        check("a5_flags", {29'd0, rx.FrameErr, rx.ParityErr, rx.BreakErr}, 32'd0);

        // Abort after four data bits of an 8-bit frame.
        p = pulses;
        WLEN = 2'b11;
        PEN  = 1'b0;
        line(1'b0, 64);
        line(1'b0, 64);
        line(1'b0, 64);
        line(1'b1, 64);
        line(1'b1, 64);
        En = 1'b0;
        line(1'b1, 20);
        En = 1'b1;
        line(1'b1, 128);
        check("abort_pulses", pulses, p);
        check("abort_data", {24'd0, rx.RxData}, 32'hA5);

        send_frame(8'hF6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        line(1'b1, 64);
        wait_drain();
        check("short_data", {24'd0, rx.RxData}, 32'h16);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
        line(1'b1, 64);
        wait_drain();
        check("par_ok", {31'd0, rx.ParityErr}, 32'd0);
        send_frame(8'h03, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        line(1'b1, 64);
        wait_drain();
        check("par_bad", {31'd0, rx.ParityErr}, 32'd1);
`endif

        send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        line(1'b1, 64);
        wait_drain();
        check("frm_data", {24'd0, rx.RxData}, 32'h55);
        check("frm_fe", {31'd0, rx.FrameErr}, 32'd1);
        check("frm_be", {31'd0, rx.BreakErr}, 32'd0);

        // Reset in the middle of a frame.
        WLEN = 2'b11;
        line(1'b0, 64);
        line(1'b1, 64);
        line(1'b0, 40);
        RESETn = 1'b0;
        line(1'b0, 1);
        check("midrst_data", {24'd0, rx.RxData}, 32'h00);
        check("midrst_fe", {31'd0, rx.FrameErr}, 32'd0);
        line(1'b1, 5);
        RESETn = 1'b1;
        line(1'b1, 128);

        // Break: line held low for three frame times gives exactly one word.
        p    = pulses;
        WLEN = 2'b11;
        PEN  = 1'b0;
        exp_q.push_back({8'h00, 1'b1, 1'b0, 1'b1});
        line(1'b0, 1920);
        check("brk_pulses", pulses, p + 1);
        check("brk_data", {24'd0, rx.RxData}, 32'h00);
        check("brk_be", {31'd0, rx.BreakErr}, 32'd1);
        line(1'b1, 128);
        check("brk_release", pulses, p + 1);
        exp_q.delete();

        p = pulses;
        line(1'b0, 12);
        line(1'b1, 300);
        check("glitch", pulses, p);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] d;
            logic [1:0] wl;
            logic       pn, ep, pb, sb;
            int         gap;
            d   = 8'($urandom);
            wl  = 2'($urandom);
            pn  = 1'($urandom);
            ep  = 1'($urandom);
            pb  = 1'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            if (k % 9 == 4) d = 8'h00;
            send_frame(d, wl, pn, ep, pb, sb);
            gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
            if (gap > 0) line(1'b1, 64 * gap);
            wait_drain();
        end
        line(1'b1, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
